// File: rtl/bp_fe_nonsynth_pkg.sv
// Shared types and constants for the FE/I$ fetch checker scoreboard.
package bp_fe_nonsynth_pkg;

    typedef enum logic [1:0] {
        e_stall_none  = 2'd0,
        e_stall_fixed = 2'd1,
        e_stall_rand  = 2'd2
    } bp_fe_stall_mode_e;

    typedef enum logic {
        e_ready = 1'b0,
        e_stall = 1'b1
    } bp_fe_stall_state_e;

    localparam int unsigned lfsr_width_gp = 16;
    // Fibonacci taps at bits 15,13,12,10 (x^16 + x^14 + x^13 + x^11 + 1)
    localparam logic [lfsr_width_gp-1:0] lfsr_taps_gp = 16'hB400;

    function automatic logic [lfsr_width_gp-1:0] lfsr_next(input logic [lfsr_width_gp-1:0] s);
        return {s[lfsr_width_gp-2:0], ^(s & lfsr_taps_gp)};
    endfunction

endpackage

// File: rtl/bp_fe_nonsynth_stall_gen.sv
// Pop throttle: after each pop, stalls for 0, a fixed, or an LFSR-random number of cycles.
module bp_fe_nonsynth_stall_gen
    import bp_fe_nonsynth_pkg::*;
#(
    parameter bp_fe_stall_mode_e         stall_mode_p = e_stall_rand,
    parameter int unsigned               max_stall_p  = 15,
    parameter logic [lfsr_width_gp-1:0]  lfsr_seed_p  = 16'hACE1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pop_i,
    output logic ready_o
);

    localparam int unsigned cnt_width_lp = $clog2(max_stall_p + 2);

    bp_fe_stall_state_e       state_r;
    logic [cnt_width_lp-1:0]  cnt_r;
    logic [cnt_width_lp-1:0]  load;
    logic [lfsr_width_gp-1:0] lfsr_r;

    // Stall length chosen at pop time, using the LFSR value before it advances.
    always_comb begin
        load = '0;
        if (stall_mode_p == e_stall_fixed)
            load = cnt_width_lp'(max_stall_p);
        else if (stall_mode_p == e_stall_rand)
            load = cnt_width_lp'(32'(lfsr_r) % (max_stall_p + 1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
            cnt_r   <= '0;
            lfsr_r  <= lfsr_seed_p;
        end else if (state_r == e_ready) begin
            if (pop_i) begin
                lfsr_r <= lfsr_next(lfsr_r);
                cnt_r  <= load;
                if (load != '0) state_r <= e_stall;
            end
        end else begin
            cnt_r <= cnt_r - cnt_width_lp'(1);
            if (cnt_r == cnt_width_lp'(1)) state_r <= e_ready;
        end
    end

    assign ready_o = (state_r == e_ready);

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read 1-write FIFO; ready is not-full only, with no same-cycle bypass.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] rptr_r, wptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    enq, deq;

    assign ready_and_o = ~reset_i & (count_r != cnt_width_lp'(els_p));
    assign v_o         = (count_r != '0);
    assign data_o      = mem_r[rptr_r];
    assign enq         = v_i & ready_and_o;
    assign deq         = yumi_i & v_o;

    // Pointers are log2(els_p) wide so they wrap modulo els_p on their own.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + ptr_width_lp'(1);
            if (deq) rptr_r <= rptr_r + ptr_width_lp'(1);
            count_r <= count_r + cnt_width_lp'(enq) - cnt_width_lp'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_fe_nonsynth_fetch_checker.sv
// In-order scoreboard pairing expected (trace) and actual (DUT) fetch data under backpressure.
module bp_fe_nonsynth_fetch_checker
    import bp_fe_nonsynth_pkg::*;
#(
    parameter int unsigned               data_width_p = 32,
    parameter int unsigned               els_p        = 16,
    parameter int unsigned               stall_mode_p = 2,
    parameter int unsigned               max_stall_p  = 15,
    parameter logic [lfsr_width_gp-1:0]  lfsr_seed_p  = 16'hACE1,
    parameter int unsigned               timeout_p    = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [data_width_p-1:0] act_data_i,
    input  logic                    act_v_i,
    output logic                    act_ready_and_o,
    input  logic [data_width_p-1:0] exp_data_i,
    input  logic                    exp_v_i,
    output logic                    exp_ready_and_o,
    output logic                    pop_v_o,
    output logic [31:0]             checked_count_o,
    output logic [31:0]             err_count_o,
    output logic                    error_o,
    output logic [data_width_p-1:0] first_exp_o,
    output logic [data_width_p-1:0] first_act_o,
    output logic [31:0]             first_idx_o,
    output logic                    timeout_o,
    output logic                    empty_o
);

    logic [data_width_p-1:0] act_head, exp_head;
    logic                    act_avail, exp_avail;
    logic                    stall_ready, pop, mismatch, act_enq;
    logic [31:0]             timer_r, timer_next;

    bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(els_p)) act_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .data_i     (act_data_i),
        .v_i        (act_v_i),
        .ready_and_o(act_ready_and_o),
        .data_o     (act_head),
        .v_o        (act_avail),
        .yumi_i     (pop)
    );

    bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(els_p)) exp_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .data_i     (exp_data_i),
        .v_i        (exp_v_i),
        .ready_and_o(exp_ready_and_o),
        .data_o     (exp_head),
        .v_o        (exp_avail),
        .yumi_i     (pop)
    );

    bp_fe_nonsynth_stall_gen #(
        .stall_mode_p(bp_fe_stall_mode_e'(2'(stall_mode_p))),
        .max_stall_p (max_stall_p),
        .lfsr_seed_p (lfsr_seed_p)
    ) stall_gen (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .pop_i  (pop),
        .ready_o(stall_ready)
    );

    assign pop      = act_avail & exp_avail & stall_ready;
    assign pop_v_o  = pop;
    assign mismatch = (exp_head != act_head);
    assign empty_o  = ~act_avail & ~exp_avail & stall_ready;
    assign act_enq  = act_v_i & act_ready_and_o;

    // Timer only runs while the DUT owes a response; it parks once it hits the limit.
    always_comb begin
        timer_next = timer_r;
        if (act_enq || !exp_avail)
            timer_next = '0;
        else if (timer_r != 32'(timeout_p))
            timer_next = timer_r + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            checked_count_o <= '0;
            err_count_o     <= '0;
            error_o         <= 1'b0;
            first_exp_o     <= '0;
            first_act_o     <= '0;
            first_idx_o     <= '0;
            timer_r         <= '0;
            timeout_o       <= 1'b0;
        end else begin
            if (pop) begin
                if (checked_count_o != '1) checked_count_o <= checked_count_o + 32'd1;
                if (mismatch) begin
                    if (err_count_o != '1) err_count_o <= err_count_o + 32'd1;
                    if (!error_o) begin
                        first_exp_o <= exp_head;
                        first_act_o <= act_head;
                        first_idx_o <= checked_count_o;
                        error_o     <= 1'b1;
                    end
                end
            end
            timer_r <= timer_next;
            if ((timeout_p != 0) && (timer_next == 32'(timeout_p))) timeout_o <= 1'b1;
        end
    end

    // The DUT may hold act_v_i while full, but must never hand over unknown data.
    always @(posedge clk_i) begin
        if (!reset_i && act_enq) assert (!$isunknown(act_data_i));
    end

endmodule

// File: tb/tb_bp_fe_nonsynth_fetch_checker.sv
// Directed bench for the fetch checker: three instances cover mode 0 / small queue / timeout, fixed stall, random stall.
module tb_bp_fe_nonsynth_fetch_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [3];
    logic [31:0] act_d   [3];
    logic [31:0] exp_d   [3];
    logic        act_v   [3];
    logic        exp_v   [3];
    logic        act_rdy [3];
    logic        exp_rdy [3];
    logic        pop_v   [3];
    logic [31:0] checked [3];
    logic [31:0] errc    [3];
    logic        error   [3];
    logic [31:0] f_exp   [3];
    logic [31:0] f_act   [3];
    logic [31:0] f_idx   [3];
    logic        tmo     [3];
    logic        empty   [3];

    bp_fe_nonsynth_fetch_checker #(.els_p(4), .stall_mode_p(0), .timeout_p(10)) u0 (
        .clk_i(clk), .reset_i(rst[0]),
        .act_data_i(act_d[0]), .act_v_i(act_v[0]), .act_ready_and_o(act_rdy[0]),
        .exp_data_i(exp_d[0]), .exp_v_i(exp_v[0]), .exp_ready_and_o(exp_rdy[0]),
        .pop_v_o(pop_v[0]), .checked_count_o(checked[0]), .err_count_o(errc[0]),
        .error_o(error[0]), .first_exp_o(f_exp[0]), .first_act_o(f_act[0]),
        .first_idx_o(f_idx[0]), .timeout_o(tmo[0]), .empty_o(empty[0])
    );

    bp_fe_nonsynth_fetch_checker #(.stall_mode_p(1), .max_stall_p(3)) u1 (
        .clk_i(clk), .reset_i(rst[1]),
        .act_data_i(act_d[1]), .act_v_i(act_v[1]), .act_ready_and_o(act_rdy[1]),
        .exp_data_i(exp_d[1]), .exp_v_i(exp_v[1]), .exp_ready_and_o(exp_rdy[1]),
        .pop_v_o(pop_v[1]), .checked_count_o(checked[1]), .err_count_o(errc[1]),
        .error_o(error[1]), .first_exp_o(f_exp[1]), .first_act_o(f_act[1]),
        .first_idx_o(f_idx[1]), .timeout_o(tmo[1]), .empty_o(empty[1])
    );

    bp_fe_nonsynth_fetch_checker u2 (
        .clk_i(clk), .reset_i(rst[2]),
        .act_data_i(act_d[2]), .act_v_i(act_v[2]), .act_ready_and_o(act_rdy[2]),
        .exp_data_i(exp_d[2]), .exp_v_i(exp_v[2]), .exp_ready_and_o(exp_rdy[2]),
        .pop_v_o(pop_v[2]), .checked_count_o(checked[2]), .err_count_o(errc[2]),
        .error_o(error[2]), .first_exp_o(f_exp[2]), .first_act_o(f_act[2]),
        .first_idx_o(f_idx[2]), .timeout_o(tmo[2]), .empty_o(empty[2])
    );

    int checks = 0;
    int errors = 0;
    int pop_cyc [8];
    int trace1  [8];
    int npop;
    int m1_exp  [4] = '{1, 5, 9, 13};
    // Seed 16'hACE1 gives stall loads 1,3,7,15 for the first four pops.
    int m2_exp  [5] = '{1, 3, 7, 15, 31};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic ev, input logic [31:0] ed,
                         input logic av, input logic [31:0] ad);
        exp_v[u] = ev;
        exp_d[u] = ed;
        act_v[u] = av;
        act_d[u] = ad;
    endtask

    task automatic do_reset(input int u);
        rst[u] = 1'b1;
        drive(u, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst[u] = 1'b0;
    endtask

    // Push n identical pairs back-to-back and record the cycles on which pop_v_o is high.
    task automatic run_pairs(input int u, input int n, input int cycles);
        npop = 0;
        for (int j = 0; j < 8; j++) pop_cyc[j] = -1;
        for (int k = 0; k < cycles; k++) begin
            if (pop_v[u] && npop < 8) begin
                pop_cyc[npop] = k;
                npop++;
            end
            if (k < n) drive(u, 1'b1, 32'h200 + k, 1'b1, 32'h200 + k);
            else       drive(u, 1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] e, a;
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1;
            drive(u, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        repeat (3) @(negedge clk);

        // Reset state
        check1("rdy_in_reset", exp_rdy[0], 1'b0);
        check1("act_rdy_in_reset", act_rdy[0], 1'b0);
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        #1;
        check1("rdy_after_reset", exp_rdy[0], 1'b1);
        check1("act_rdy_after_reset", act_rdy[0], 1'b1);
        check("checked_reset", checked[0], 32'd0);
        check("errc_reset", errc[0], 32'd0);
        check1("error_reset", error[0], 1'b0);
        check("first_idx_reset", f_idx[0], 32'd0);
        check("first_exp_reset", f_exp[0], 32'd0);
        check1("timeout_reset", tmo[0], 1'b0);
        check1("empty_reset", empty[0], 1'b1);
        @(negedge clk);

        // Mode 0: 8 matching pairs, pops on 8 consecutive cycles
        for (int i = 0; i < 10; i++) begin
            check1($sformatf("m0_pop_c%0d", i), pop_v[0], (i >= 1 && i <= 8));
            if (i < 8) drive(0, 1'b1, 32'h13 + i, 1'b1, 32'h13 + i);
            else       drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
        end
        check("m0_checked", checked[0], 32'd8);
        check("m0_errc", errc[0], 32'd0);
        check1("m0_error", error[0], 1'b0);

        // Mode 0: mismatches on pair 3 and pair 5
        do_reset(0);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                check("mm_errc_first", errc[0], 32'd1);
                check1("mm_error_first", error[0], 1'b1);
                check("mm_idx_first", f_idx[0], 32'd3);
            end
            e = 32'h1000 + i;
            a = e;
            if (i == 3) begin
                e = 32'hDEADBEEF;
                a = 32'hDEADBEEE;
            end else if (i == 5) begin
                a = 32'h1006;
            end
            if (i < 6) drive(0, 1'b1, e, 1'b1, a);
            else       drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
        end
        check("mm_errc", errc[0], 32'd2);
        check("mm_checked", checked[0], 32'd6);
        check("mm_first_idx", f_idx[0], 32'd3);
        check("mm_first_exp", f_exp[0], 32'hDEADBEEF);
        check("mm_first_act", f_act[0], 32'hDEADBEEE);

        // els_p=4: fill the actual queue, then drain one entry
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 32'h0, 1'b1, 32'h3000 + i);
            @(negedge clk);
            if (i == 2) check1("full_rdy_3", act_rdy[0], 1'b1);
        end
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        check1("full_rdy_4", act_rdy[0], 1'b0);
        check1("full_no_pop", pop_v[0], 1'b0);
        drive(0, 1'b1, 32'h3000, 1'b0, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        check1("full_pop", pop_v[0], 1'b1);
        check1("full_rdy_pop_cycle", act_rdy[0], 1'b0);
        @(negedge clk);
        check1("full_rdy_after_pop", act_rdy[0], 1'b1);
        check1("full_single_pop", pop_v[0], 1'b0);
        check("full_checked", checked[0], 32'd7);
        check("full_errc", errc[0], 32'd2);

        // Mid-stream reset discards the three buffered actuals
        do_reset(0);
        check1("rst_empty", empty[0], 1'b1);
        check("rst_checked", checked[0], 32'd0);
        check1("rst_error", error[0], 1'b0);

        // Timeout: expected only, no actual
        drive(0, 1'b1, 32'h4000, 1'b0, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        check1("tmo_before", tmo[0], 1'b0);
        @(negedge clk);
        check1("tmo_at_10", tmo[0], 1'b1);

        // Timeout avoided by an actual arriving after 4 cycles
        do_reset(0);
        drive(0, 1'b1, 32'h4100, 1'b0, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b1, 32'h4100);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (15) @(negedge clk);
        check1("tmo_avoided", tmo[0], 1'b0);
        check("tmo_avoided_checked", checked[0], 32'd1);
        check("tmo_avoided_errc", errc[0], 32'd0);

        // Mode 1, max_stall_p=3: pops spaced exactly 4 apart
        run_pairs(1, 4, 20);
        check("m1_npop", npop, 32'd4);
        for (int j = 0; j < 4; j++) check($sformatf("m1_pop%0d", j), pop_cyc[j], m1_exp[j]);
        check("m1_checked", checked[1], 32'd4);

        // Mode 2: LFSR-driven spacing from the seed
        run_pairs(2, 5, 50);
        check("m2_npop", npop, 32'd5);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("m2_pop%0d", j), pop_cyc[j], m2_exp[j]);
            trace1[j] = pop_cyc[j];
        end
        check("m2_checked", checked[2], 32'd5);

        // Mode 2: reset with pairs buffered, then replay
        do_reset(2);
        for (int k = 0; k < 5; k++) begin
            drive(2, 1'b1, 32'h200 + k, 1'b1, 32'h200 + k);
            @(negedge clk);
        end
        check("m2_pre_reset_checked", checked[2], 32'd2);
        rst[2] = 1'b1;
        drive(2, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("m2_rst_checked", checked[2], 32'd0);
        check("m2_rst_errc", errc[2], 32'd0);
        check1("m2_rst_empty", empty[2], 1'b1);
        check1("m2_rst_pop", pop_v[2], 1'b0);
        rst[2] = 1'b0;
        run_pairs(2, 5, 50);
        check("m2_replay_npop", npop, 32'd5);
        for (int j = 0; j < 5; j++) check($sformatf("m2_replay%0d", j), pop_cyc[j], trace1[j]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_nonsynth_fetch_checker.md
Name: bp_fe_nonsynth_fetch_checker

Overview:
Nonsynthesizable scoreboard for FE/I$ unit benches. It replaces the fixed 16-entry output FIFO plus random-yumi pairing used by I$ benches. Expected fetch data (from trace replay) and actual fetch data (from the DUT) are each buffered in parametrised queues, popped in pairs under a configurable backpressure mode, and compared in order. It reports mismatch counts, a captured first-mismatch record, and a response-timeout flag.

Parameters:
data_width_p, 32, width of fetched data (instr_width_gp for I$)
els_p, 16, depth of each queue; power of 2, >=2
stall_mode_p, 2, 0 = never stall; 1 = fixed stall of max_stall_p cycles after every pop; 2 = LFSR-random stall 0..max_stall_p
max_stall_p, 15, maximum stall cycles between pops
lfsr_seed_p, 16'hACE1, nonzero seed for the 16-bit Fibonacci LFSR
timeout_p, 1024, cycles with expected queue non-empty and no actual arrival before timeout_o sets; 0 disables the timeout

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
act_data_i  in  data_width_p  DUT fetch data
act_v_i  in  1  DUT data valid
act_ready_and_o  out  1  actual-queue not full
exp_data_i  in  data_width_p  expected data from trace replay
exp_v_i  in  1  expected valid
exp_ready_and_o  out  1  expected-queue not full
pop_v_o  in/out: out  1  pulses on the cycle a pair is compared
checked_count_o  out  32  pairs compared, saturating
err_count_o  out  32  mismatching pairs, saturating
error_o  out  1  sticky; set on first mismatch
first_exp_o  out  data_width_p  expected value of first mismatch
first_act_o  out  data_width_p  actual value of first mismatch
first_idx_o  out  32  checked_count value at first mismatch
timeout_o  out  1  sticky response timeout
empty_o  out  1  both queues empty and not stalled

Behaviour:
- Reset, synchronous: queues are emptied; all counters, sticky flags, and first_* outputs go to 0; stall FSM enters READY; LFSR loads lfsr_seed_p. A reset mid-stream discards all buffered data. Ready outputs are 0 during reset and 1 on the first cycle after it.
- Queues:
  - Independent 1r1w queues, each els_p deep.
  - Enqueue occurs when v_i & ready_and_o.
  - ready_and_o = ~full, with no bypass when full, even if a pop happens in the same cycle.
  - Enqueue to an empty queue becomes visible for popping on the next cycle.
  - Pointers wrap modulo els_p.
- Pop:
  - pop = both queues non-empty & stall FSM in READY.
  - Both heads dequeue in the same cycle.
  - Compare is combinational; pop_v_o = pop.
  - Counter and flag updates appear on the cycle after the pop.
- Mismatch (exp head != act head on a pop):
  - err_count increments, saturating at 2^32-1.
  - If error_o is 0: capture first_exp_o, first_act_o, and first_idx_o (the pre-increment checked_count value), then set error_o.
  - Later mismatches do not overwrite the captured record.
- Stall FSM (READY/STALL):
  - On a pop, load stall_cnt: mode 0 loads 0; mode 1 loads max_stall_p; mode 2 loads LFSR[15:0] mod (max_stall_p+1).
  - If the loaded value is nonzero, go to STALL; otherwise stay in READY.
  - STALL decrements stall_cnt each cycle and returns to READY on the cycle after it reaches 1.
  - LFSR advances only on pops, so sequences are reproducible per seed.
- Timeout:
  - The counter resets to 0 on any actual enqueue or whenever the expected queue is empty.
  - Otherwise it increments each cycle; timeout_o sets when it reaches timeout_p.
- Asserts (sim only):
  - act_v_i while full is permitted (the DUT is holding).
  - X on act_data_i during an enqueue is an error.

Decomposition:
- Shared package bp_fe_nonsynth_pkg: stall-mode enum e_stall_none/e_stall_fixed/e_stall_rand; LFSR tap constant.
- Queues are instances of bsg_fifo_1r1w_small.
- One natural sub-module, bp_fe_nonsynth_stall_gen: LFSR plus stall FSM, with ports clk_i, reset_i, pop_i, ready_o.

Test Plan:
- Mode 0, 8 identical pairs 32'h0000_0013..1A, both streams valid back-to-back -> pops on 8 consecutive cycles starting 1 cycle after the first pair enqueues; checked_count=8; err_count=0; error_o=0.
- Mode 0, pair 3 has exp=32'hDEADBEEF, act=32'hDEADBEEE; pair 5 also mismatches -> err_count=2; first_idx_o=3; first_exp_o=DEADBEEF; first_act_o=DEADBEEE, unchanged after pair 5.
- els_p=4: push 4 actual with no expected -> act_ready_and_o=0 on the cycle after the 4th enqueue; push 1 expected -> one pop, and ready returns to 1 on the following cycle.
- Mode 1, max_stall_p=3: 4 pairs preloaded -> pop cycles spaced exactly 4 apart; checked_count=4.
- timeout_p=10: push 1 expected, no actual -> timeout_o=1 exactly 10 cycles after the enqueue; an actual arriving earlier prevents it.
- Mode 2, reset asserted with 5 buffered pairs -> on the next cycle counters=0, empty_o=1, and the same seed reproduces an identical pop-cycle trace.
